// File: rtl/load_store_unit_if.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// Module   : load_store_unit_if
// Purpose  : Request/response handshake and word-memory bus of the LSU.
//            slave  = the load/store unit, master = execute stage + memory.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
interface load_store_unit_if;
  logic        Start;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] Addr;
  logic [31:0] StoreData;
  logic        Busy;
  logic        Done;
  logic [31:0] LoadData;
  logic [1:0]  Fault;
  logic [31:0] MemAddress;
  logic [31:0] MemWriteData;
  logic        MemWriteEnable;
  logic [31:0] MemReadData;

  modport slave (
    input  Start, MemRead, MemWrite, Funct3, Addr, StoreData, MemReadData,
    output Busy, Done, LoadData, Fault, MemAddress, MemWriteData, MemWriteEnable
  );

  modport master (
    output Start, MemRead, MemWrite, Funct3, Addr, StoreData, MemReadData,
    input  Busy, Done, LoadData, Fault, MemAddress, MemWriteData, MemWriteEnable
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// Module   : load_store_unit
// Purpose  : RV32I load/store engine in front of a word-addressed memory with
//            registered read data. Sub-word stores are read-modify-write.
//            Faulting requests complete immediately without memory access.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int MEM_WORDS = 64
) (
  input  logic               CLK,
  input  logic               RESET,
  load_store_unit_if.slave   bus
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    LATCH = 3'd2,
    MERGE = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t      state;
  logic        is_store;
  logic [2:0]  funct3;
  logic [1:0]  lane;
  logic [31:0] store_data;
  logic [31:0] old_word;

  logic [1:0]  req_fault;
  logic [31:0] load_ext;
  logic [31:0] merged;

  // Classify the incoming request: illegal code, then misalignment, then range
  always_comb begin
    req_fault = 2'b00;
    if (bus.MemWrite ? (bus.Funct3[2] || bus.Funct3[1:0] == 2'b11)
                     : (bus.Funct3[1:0] == 2'b11 || bus.Funct3 == 3'b110))
      req_fault = 2'b11;
    else if ((bus.Funct3[1:0] == 2'b01 && bus.Addr[0]) ||
             (bus.Funct3[1:0] == 2'b10 && bus.Addr[1:0] != 2'b00))
      req_fault = 2'b01;
    else if ({2'b00, bus.Addr[31:2]} >= MEM_LIMIT)
      req_fault = 2'b10;
  end

  // Pick the addressed lane out of the returned word and extend it
  always_comb begin
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    case (lane)
      2'd0:    sel_byte = bus.MemReadData[7:0];
      2'd1:    sel_byte = bus.MemReadData[15:8];
      2'd2:    sel_byte = bus.MemReadData[23:16];
      default: sel_byte = bus.MemReadData[31:24];
    endcase
    sel_half = lane[1] ? bus.MemReadData[31:16] : bus.MemReadData[15:0];
    case (funct3)
      3'b000:  load_ext = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  load_ext = {24'd0, sel_byte};
      3'b001:  load_ext = {{16{sel_half[15]}}, sel_half};
      3'b101:  load_ext = {16'd0, sel_half};
      default: load_ext = bus.MemReadData;
    endcase
  end

  // Replace only the target byte or half of the previously read word
  always_comb begin
    merged = old_word;
    if (funct3[1:0] == 2'b00) begin
      case (lane)
        2'd0:    merged[7:0]   = store_data[7:0];
        2'd1:    merged[15:8]  = store_data[7:0];
        2'd2:    merged[23:16] = store_data[7:0];
        default: merged[31:24] = store_data[7:0];
      endcase
    end else if (lane[1]) begin
      merged[31:16] = store_data[15:0];
    end else begin
      merged[15:0] = store_data[15:0];
    end
  end

  // Sequencer; every output is a register so the memory sees glitch-free strobes
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state              <= IDLE;
      is_store           <= 1'b0;
      funct3             <= 3'd0;
      lane               <= 2'd0;
      store_data         <= 32'd0;
      old_word           <= 32'd0;
      bus.Busy           <= 1'b0;
      bus.Done           <= 1'b0;
      bus.LoadData       <= 32'd0;
      bus.Fault          <= 2'b00;
      bus.MemAddress     <= 32'd0;
      bus.MemWriteData   <= 32'd0;
      bus.MemWriteEnable <= 1'b0;
    end else begin
      bus.Done           <= 1'b0;
      bus.MemWriteEnable <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Start && (bus.MemRead || bus.MemWrite)) begin
            is_store       <= bus.MemWrite;
            funct3         <= bus.Funct3;
            lane           <= bus.Addr[1:0];
            store_data     <= bus.StoreData;
            bus.MemAddress <= {2'b00, bus.Addr[31:2]};
            bus.Fault      <= req_fault;
            bus.Busy       <= 1'b1;
            if (req_fault != 2'b00) begin
              state    <= DONE;
              bus.Done <= 1'b1;
            end else if (bus.MemWrite && bus.Funct3 == 3'b010) begin
              // Full-word store needs no read of the old contents
              state              <= WRITE;
              bus.MemWriteData   <= bus.StoreData;
              bus.MemWriteEnable <= 1'b1;
            end else begin
              state <= READ;
            end
          end
        end
        READ: state <= LATCH;
        LATCH: begin
          if (is_store) begin
            old_word <= bus.MemReadData;
            state    <= MERGE;
          end else begin
            bus.LoadData <= load_ext;
            bus.Done     <= 1'b1;
            state        <= DONE;
          end
        end
        MERGE: begin
          bus.MemWriteData   <= merged;
          bus.MemWriteEnable <= 1'b1;
          state              <= WRITE;
        end
        WRITE: begin
          bus.Done <= 1'b1;
          state    <= DONE;
        end
        default: begin
          bus.Busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// Module   : tb_load_store_unit
// Purpose  : Self-checking bench for load_store_unit with a registered-read
//            word memory and a byte-level reference model.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_load_store_unit;
  localparam int MEM_WORDS = 64;

  logic CLK = 1'b0;
  logic RESET;
  load_store_unit_if bus();

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // Attached data memory: synchronous write, registered read
  logic [31:0] mem [MEM_WORDS];
  logic        pre_en = 1'b0;
  logic [5:0]  pre_idx = 6'd0;
  logic [31:0] pre_val = 32'd0;
  always @(posedge CLK) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    else if (bus.MemWriteEnable) mem[bus.MemAddress[5:0]] <= bus.MemWriteData;
    bus.MemReadData <= mem[bus.MemAddress[5:0]];
  end

  // Reference model: memory as a flat byte array plus the held load result
  logic [7:0]  ref_bytes [MEM_WORDS*4];
  logic [31:0] held;
  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] exp_data;
    logic [1:0]  exp_fault;
    int          exp_lat;
    int          exp_we;
  } vec_t;
  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge CLK);
    pre_en = 1'b1; pre_idx = 6'(idx); pre_val = val;
    for (int b = 0; b < 4; b++) ref_bytes[idx*4+b] = val[8*b +: 8];
    @(negedge CLK);
    pre_en = 1'b0;
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [1:0] model_fault(input bit st, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal) return 2'b11;
    if (a % nbytes(f3) != 0) return 2'b01;
    if (a / 4 >= MEM_WORDS) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    int i;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    i = int'(a[7:0]);
    b = ref_bytes[i];
    h = {ref_bytes[(i+1)%256], b};
    w = {ref_bytes[(i+3)%256], ref_bytes[(i+2)%256], h};
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd4:    return {24'd0, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd5:    return {16'd0, h};
      default: return w;
    endcase
  endfunction

  function automatic void model_apply(input bit st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd);
    if (model_fault(st, f3, a) != 2'b00) return;
    if (st) begin
      for (int b = 0; b < nbytes(f3); b++) ref_bytes[int'(a[7:0]) + b] = sd[8*b +: 8];
    end else begin
      held = model_load(f3, a);
    end
  endfunction

  // Issue one request and count cycles from acceptance to Done
  task automatic run_req(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, output int lat, output int we_cnt, output bit busy_ok);
    @(negedge CLK);
    bus.Start = 1'b1; bus.MemRead = rd; bus.MemWrite = wr;
    bus.Funct3 = f3; bus.Addr = a; bus.StoreData = sd;
    @(negedge CLK);
    bus.Start = 1'b0; bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
    lat = 1; we_cnt = 0; busy_ok = 1'b1;
    while (1) begin
      if (bus.MemWriteEnable) we_cnt++;
      if (!bus.Busy) busy_ok = 1'b0;
      if (bus.Done || lat >= 20) break;
      @(negedge CLK);
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input logic [31:0] exp_data,
                       input logic [1:0] exp_fault, input int exp_lat, input int exp_we);
    int lat, we_cnt;
    bit busy_ok;
    run_req(rd, wr, f3, a, sd, lat, we_cnt, busy_ok);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " fault"}, {30'd0, bus.Fault}, {30'd0, exp_fault});
    check({tag, " loaddata"}, bus.LoadData, exp_data);
    check({tag, " we_pulses"}, 32'(we_cnt), 32'(exp_we));
    check({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
  endtask

  initial begin
    bus.Start = 0; bus.MemRead = 0; bus.MemWrite = 0;
    bus.Funct3 = 0; bus.Addr = 0; bus.StoreData = 0;
    held = 32'd0;
    RESET = 1'b1;
    #1;
    check("reset busy", {31'd0, bus.Busy}, 32'd0);
    check("reset done", {31'd0, bus.Done}, 32'd0);
    check("reset we", {31'd0, bus.MemWriteEnable}, 32'd0);
    check("reset loaddata", bus.LoadData, 32'd0);
    check("reset fault", {30'd0, bus.Fault}, 32'd0);
    check("reset memaddress", bus.MemAddress, 32'd0);
    check("reset memwritedata", bus.MemWriteData, 32'd0);

    for (int i = 0; i < MEM_WORDS; i++) preload(i, $urandom);
    preload(0, 32'hCAFE_F00D);
    preload(1, 32'h8081_F2F3);
    preload(2, 32'h1122_3344);
    @(negedge CLK);
    RESET = 1'b0;

    //          rd wr f3    addr          sd             exp_data       flt lat we
    vecs[0]  = '{1, 0, 3'd0, 32'd4,       32'd0,         32'hFFFF_FFF3, 2'd0, 3, 0};
    vecs[1]  = '{1, 0, 3'd4, 32'd7,       32'd0,         32'h0000_0080, 2'd0, 3, 0};
    vecs[2]  = '{1, 0, 3'd5, 32'd6,       32'd0,         32'h0000_8081, 2'd0, 3, 0};
    vecs[3]  = '{1, 0, 3'd1, 32'd4,       32'd0,         32'hFFFF_F2F3, 2'd0, 3, 0};
    vecs[4]  = '{0, 1, 3'd0, 32'd9,       32'h1234_56AB, 32'hFFFF_F2F3, 2'd0, 5, 1};
    vecs[5]  = '{1, 0, 3'd2, 32'd8,       32'd0,         32'h1122_AB44, 2'd0, 3, 0};
    vecs[6]  = '{1, 1, 3'd2, 32'd12,      32'hDEAD_BEEF, 32'h1122_AB44, 2'd0, 2, 1};
    vecs[7]  = '{1, 0, 3'd2, 32'd12,      32'd0,         32'hDEAD_BEEF, 2'd0, 3, 0};
    vecs[8]  = '{1, 0, 3'd2, 32'd6,       32'd0,         32'hDEAD_BEEF, 2'd1, 1, 0};
    vecs[9]  = '{0, 1, 3'd1, 32'd256,     32'd0,         32'hDEAD_BEEF, 2'd2, 1, 0};
    vecs[10] = '{1, 0, 3'd3, 32'd0,       32'd0,         32'hDEAD_BEEF, 2'd3, 1, 0};
    vecs[11] = '{0, 1, 3'd4, 32'd1,       32'd0,         32'hDEAD_BEEF, 2'd3, 1, 0};
    vecs[12] = '{1, 0, 3'd1, 32'h1001,    32'd0,         32'hDEAD_BEEF, 2'd1, 1, 0};
    vecs[13] = '{1, 0, 3'd2, 32'd0,       32'd0,         32'hCAFE_F00D, 2'd0, 3, 0};
    vecs[14] = '{0, 1, 3'd1, 32'd2,       32'h0000_BEEF, 32'hCAFE_F00D, 2'd0, 5, 1};
    vecs[15] = '{1, 0, 3'd0, 32'd3,       32'd0,         32'hFFFF_FFBE, 2'd0, 3, 0};
    vecs[16] = '{0, 1, 3'd2, 32'd252,     32'h0123_4567, 32'hFFFF_FFBE, 2'd0, 2, 1};
    vecs[17] = '{1, 0, 3'd5, 32'd254,     32'd0,         32'h0000_0123, 2'd0, 3, 0};
    vecs[18] = '{1, 0, 3'd4, 32'd255,     32'd0,         32'h0000_0001, 2'd0, 3, 0};
    for (int v = 0; v < 19; v++) begin
      do_op($sformatf("vec%0d", v), vecs[v].rd, vecs[v].wr, vecs[v].f3, vecs[v].addr,
            vecs[v].sd, vecs[v].exp_data, vecs[v].exp_fault, vecs[v].exp_lat, vecs[v].exp_we);
      model_apply(vecs[v].wr, vecs[v].f3, vecs[v].addr, vecs[v].sd);
    end

    // Start with neither MemRead nor MemWrite is not a request
    @(negedge CLK);
    bus.Start = 1'b1; bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
    @(negedge CLK);
    bus.Start = 1'b0;
    check("noop busy", {31'd0, bus.Busy}, 32'd0);
    @(negedge CLK);
    check("noop done", {31'd0, bus.Done}, 32'd0);

    // A second Start while busy with a SW must be ignored
    @(negedge CLK);
    bus.Start = 1'b1; bus.MemWrite = 1'b1; bus.Funct3 = 3'd2;
    bus.Addr = 32'd16; bus.StoreData = 32'h1111_1111;
    @(negedge CLK);
    bus.Addr = 32'd20; bus.StoreData = 32'h2222_2222;
    @(negedge CLK);
    bus.Start = 1'b0; bus.MemWrite = 1'b0;
    check("busy-start done", {31'd0, bus.Done}, 32'd1);
    @(negedge CLK);
    check("busy-start idle", {31'd0, bus.Busy}, 32'd0);
    @(negedge CLK);
    check("busy-start stays idle", {31'd0, bus.Busy}, 32'd0);
    model_apply(1'b1, 3'd2, 32'd16, 32'h1111_1111);

    // Reset in the WRITE cycle of an SB aborts the write
    @(negedge CLK);
    bus.Start = 1'b1; bus.MemWrite = 1'b1; bus.Funct3 = 3'd0;
    bus.Addr = 32'd25; bus.StoreData = 32'h0000_00AA;
    @(negedge CLK);
    bus.Start = 1'b0; bus.MemWrite = 1'b0;
    repeat (3) @(negedge CLK);
    check("sb write strobe", {31'd0, bus.MemWriteEnable}, 32'd1);
    RESET = 1'b1;
    #1;
    check("abort we", {31'd0, bus.MemWriteEnable}, 32'd0);
    check("abort busy", {31'd0, bus.Busy}, 32'd0);
    check("abort done", {31'd0, bus.Done}, 32'd0);
    check("abort loaddata", bus.LoadData, 32'd0);
    check("abort fault", {30'd0, bus.Fault}, 32'd0);
    check("abort memaddress", bus.MemAddress, 32'd0);
    check("abort memwritedata", bus.MemWriteData, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    held = 32'd0;

    // Randomized traffic against the byte-level model
    for (int n = 0; n < 150; n++) begin
      bit st, rd;
      logic [2:0] f3;
      logic [31:0] a;
      logic [1:0] ef;
      int el, ew;
      st = $urandom_range(0, 1) == 1;
      rd = st ? ($urandom_range(0, 3) == 0) : 1'b1;
      if ($urandom_range(0, 3) != 0) begin
        if (st) f3 = 3'($urandom_range(0, 2));
        else begin
          case ($urandom_range(0, 4))
            0: f3 = 3'd0;
            1: f3 = 3'd1;
            2: f3 = 3'd2;
            3: f3 = 3'd4;
            default: f3 = 3'd5;
          endcase
        end
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      a = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 255));
      if ($urandom_range(0, 2) != 0) a = a & ~32'(nbytes(f3) - 1);
      ef = model_fault(st, f3, a);
      el = (ef != 2'b00) ? 1 : (st ? ((f3 == 3'd2) ? 2 : 5) : 3);
      ew = (ef == 2'b00 && st) ? 1 : 0;
      model_apply(st, f3, a, 32'($urandom) ^ 32'(n));
      do_op($sformatf("rnd%0d", n), rd, st, f3, a,
            {ref_bytes[(int'(a[7:0])+3)%256], ref_bytes[(int'(a[7:0])+2)%256],
             ref_bytes[(int'(a[7:0])+1)%256], ref_bytes[int'(a[7:0])]},
            held, ef, el, ew);
    end

    @(negedge CLK);
    for (int i = 0; i < MEM_WORDS; i++)
      check($sformatf("mem[%0d]", i), mem[i],
            {ref_bytes[i*4+3], ref_bytes[i*4+2], ref_bytes[i*4+1], ref_bytes[i*4]});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
